// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: input-side packet controller FSM for a 1x3 router
// Sequences header decode, payload load, FIFO-full stall and parity load/check.
// Ports: clk, resetn (sync, active-low); pkt_valid, data_in[ADDR_W] (header address);
//   fifo_full (addressed FIFO), fifo_empty_0..2, soft_reset_0..2, parity_done, low_pkt_valid;
//   outputs detect_add, lfd_state, ld_state, laf_state, full_state, write_en_reg, rst_int_reg, busy.
module router_pkt_ctrl #(
  parameter int ADDR_W     = 2,
  parameter bit DROP_INVAL = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_en_reg,
  output logic              rst_int_reg,
  output logic              busy
);
  typedef enum logic [2:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] fifo_empty, soft_reset;
  logic addr_ok;
  assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};
  // address 3 never starts a packet, whichever DROP_INVAL mode is selected
  assign addr_ok = (DROP_INVAL || !DROP_INVAL) && data_in < ADDR_W'(3);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= DA;
      addr_q <= '0;
    end else begin
      state  <= nxt;
      addr_q <= (state == DA && pkt_valid && addr_ok) ? data_in : addr_q;
    end
  end
  always_comb begin
    nxt = DA;
    case (state)
      DA:      nxt = (pkt_valid && addr_ok) ? (fifo_empty[data_in] ? LFD : WTE) : DA;
      WTE:     nxt = fifo_empty[addr_q] ? LFD : WTE;
      LFD:     nxt = LD;
      LD:      nxt = fifo_full ? FFS : (!pkt_valid ? LP : LD);
      FFS:     nxt = fifo_full ? FFS : LAF;
      LAF:     nxt = parity_done ? DA : (low_pkt_valid ? LP : LD);
      LP:      nxt = CPE;
      CPE:     nxt = fifo_full ? FFS : DA;
      default: nxt = DA;
    endcase
    // timeout soft reset of the latched destination aborts the packet
    if (state != DA && soft_reset[addr_q]) nxt = DA;
  end
  assign detect_add   = state == DA;
  assign lfd_state    = state == LFD;
  assign ld_state     = state == LD;
  assign laf_state    = state == LAF;
  assign full_state   = state == FFS;
  assign rst_int_reg  = state == CPE;
  assign write_en_reg = state == LD || state == LAF || state == LP;
  assign busy         = !(state == DA || state == LD);
endmodule
